// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned NUM_REQ_DEF   = 4;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned BURST_LEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    STALL = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set req index after last_ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ_DEF)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    logic [31:0] w_cand;
    idx    = '0;
    valid  = 1'b0;
    w_cand = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      w_cand = (32'(last_ptr) + off) % NUM_REQ;
      if (!valid && req[w_cand[IDX_W-1:0]]) begin
        idx   = w_cand[IDX_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with full/almost_full stall handling and a registered write path.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic                        clk_write,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic                        full,
  input  logic                        almost_full,
  output logic [DATA_W-1:0]           data_in,
  output logic                        write_enable,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned BW    = $clog2(BURST_LEN) + 1;
  localparam logic [BW-1:0]    BEAT_LAST = BW'(BURST_LEN);
  localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(NUM_REQ - 1);

  arb_state_t         r_state;
  logic [BW-1:0]      r_beat_cnt;
  logic [IDX_W-1:0]   r_last_ptr;

  logic               w_stall;
  logic               w_req_own;
  logic               w_beat;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_valid;
  logic [DATA_W-1:0]  w_sel_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last_ptr (r_last_ptr),
    .idx      (w_pick_idx),
    .valid    (w_pick_valid)
  );

  // Grant is combinational so the producer sees consumption in the same cycle.
  always_comb begin
    w_stall    = full | almost_full;
    w_req_own  = req[owner];
    w_beat     = (r_state == BURST) && w_req_own && !w_stall;
    w_sel_data = req_data[int'(owner)*DATA_W +: DATA_W];
    gnt        = '0;
    if (w_beat) gnt[owner] = 1'b1;
  end

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk_write) begin
    if (rst) begin
      r_state      <= IDLE;
      r_beat_cnt   <= '0;
      r_last_ptr   <= PTR_INIT;
      owner        <= '0;
      data_in      <= '0;
      write_enable <= 1'b0;
    end else begin
      write_enable <= w_beat;
      if (w_beat) data_in <= w_sel_data;

      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            owner      <= w_pick_idx;
            r_beat_cnt <= '0;
            r_state    <= BURST;
          end
        end
        BURST: begin
          if (!w_req_own) begin
            r_last_ptr <= owner;
            r_state    <= IDLE;
          end else if (w_stall) begin
            r_state <= STALL;
          end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (r_beat_cnt + 1'b1 == BEAT_LAST) begin
              r_last_ptr <= owner;
              r_state    <= IDLE;
            end
          end
        end
        STALL: begin
          if (!w_req_own) begin
            r_last_ptr <= owner;
            r_state    <= IDLE;
          end else if (!w_stall) begin
            r_state <= BURST;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with hand-computed expectations.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  logic        clk_write = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        full;
  logic        almost_full;
  logic [7:0]  data_in;
  logic        write_enable;
  logic [1:0]  owner;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int we_cnt;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .BURST_LEN (4)
  ) dut (
    .clk_write    (clk_write),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .full         (full),
    .almost_full  (almost_full),
    .data_in      (data_in),
    .write_enable (write_enable),
    .owner        (owner),
    .busy         (busy)
  );

  always #5 clk_write = ~clk_write;

  task automatic step();
    @(posedge clk_write);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; full = 1'b0; almost_full = 1'b0;
    step(); step();
    chk("rst_gnt",   32'(gnt), 0);
    chk("rst_we",    32'(write_enable), 0);
    chk("rst_data",  32'(data_in), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    rst = 1'b0;

    // Single requester, six words 0x11..0x16
    req = 4'b0001; req_data[7:0] = 8'h11; #1;
    chk("t1_idle_gnt", 32'(gnt), 0);
    step();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_gnt0", 32'(gnt), 32'h1);
    chk("t1_we0",  32'(write_enable), 0);
    for (int b = 0; b < 4; b++) begin
      step();
      chk("t1_we",   32'(write_enable), 1);
      chk("t1_data", 32'(data_in), 32'(8'h11 + b));
      req_data[7:0] = 8'(8'h12 + b);
      if (b < 3) chk("t1_gnt", 32'(gnt), 32'h1);
    end
    chk("t1_end_busy", 32'(busy), 0);
    chk("t1_end_gnt",  32'(gnt), 0);
    step();
    chk("t1_gap_we", 32'(write_enable), 0);
    chk("t1_t2_gnt", 32'(gnt), 32'h1);
    step();
    chk("t1_w15_we",   32'(write_enable), 1);
    chk("t1_w15_data", 32'(data_in), 32'h15);
    req_data[7:0] = 8'h16;
    step();
    chk("t1_w16_we",   32'(write_enable), 1);
    chk("t1_w16_data", 32'(data_in), 32'h16);
    req = '0;
    step();
    chk("t1_drop_busy", 32'(busy), 0);
    chk("t1_drop_we",   32'(write_enable), 0);
    chk("t1_drop_hold", 32'(data_in), 32'h16);

    // All four requesting: order 0,1,2,3,0 with four beats each
    rst = 1'b1; req = 4'b1111; req_data = 32'h44332211;
    step();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      step();
      chk("t2_owner", 32'(owner), 32'(t % 4));
      chk("t2_gnt",   32'(gnt), 32'(1 << (t % 4)));
      chk("t2_we_gap", 32'(write_enable), 0);
      for (int b = 0; b < 4; b++) begin
        step();
        chk("t2_we",   32'(write_enable), 1);
        chk("t2_data", 32'(data_in), 32'(8'h11 * ((t % 4) + 1)));
        chk("t2_gnt_b", 32'(gnt), (b < 3) ? 32'(1 << (t % 4)) : 32'h0);
      end
      chk("t2_idle", 32'(busy), 0);
    end

    // almost_full after the 2nd beat: stall, then two remaining beats
    req = 4'b0010; req_data = 32'h00_00_A5_00; we_cnt = 0;
    step();
    chk("t3_owner", 32'(owner), 1);
    chk("t3_gnt",   32'(gnt), 32'h2);
    step(); we_cnt += int'(write_enable);
    step(); we_cnt += int'(write_enable);
    chk("t3_data", 32'(data_in), 32'hA5);
    almost_full = 1'b1; #1;
    chk("t3_af_gnt", 32'(gnt), 0);
    step(); we_cnt += int'(write_enable);
    chk("t3_stall",    32'(dut.r_state), 32'(STALL));
    chk("t3_stall_we", 32'(write_enable), 0);
    step(); we_cnt += int'(write_enable);
    chk("t3_stall_gnt", 32'(gnt), 0);
    almost_full = 1'b0; #1;
    chk("t3_stall_gnt2", 32'(gnt), 0);
    step(); we_cnt += int'(write_enable);
    chk("t3_burst", 32'(dut.r_state), 32'(BURST));
    chk("t3_resume_gnt", 32'(gnt), 32'h2);
    step(); we_cnt += int'(write_enable);
    step(); we_cnt += int'(write_enable);
    chk("t3_done_busy", 32'(busy), 0);
    chk("t3_we_count", 32'(we_cnt), 4);
    chk("t3_last_ptr", 32'(dut.r_last_ptr), 1);

    // req[owner] dropped during STALL
    req = 4'b0101;
    step();
    chk("t4_owner", 32'(owner), 2);
    full = 1'b1; #1;
    chk("t4_full_gnt", 32'(gnt), 0);
    step();
    chk("t4_stall", 32'(dut.r_state), 32'(STALL));
    req = 4'b1001;
    step();
    chk("t4_idle",     32'(busy), 0);
    chk("t4_last_ptr", 32'(dut.r_last_ptr), 2);
    full = 1'b0;
    step();
    chk("t4_next_owner", 32'(owner), 3);
    chk("t4_next_gnt",   32'(gnt), 32'h8);
    req = '0;
    step();
    chk("t4_end", 32'(busy), 0);

    // Reset on the 3rd beat of requester 2
    req = 4'b0100; req_data = 32'h00_C3_00_00;
    step();
    chk("t5_owner", 32'(owner), 2);
    step(); step();
    chk("t5_gnt_b3", 32'(gnt), 32'h4);
    rst = 1'b1;
    step();
    chk("t5_rst_we",   32'(write_enable), 0);
    chk("t5_rst_gnt",  32'(gnt), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    rst = 1'b0; req = 4'b0101;
    step();
    chk("t5_first_owner", 32'(owner), 0);
    chk("t5_first_gnt",   32'(gnt), 32'h1);
    req = '0;
    step();

    // full held high for 10 cycles with everyone requesting
    req = 4'b1111; req_data = 32'h00_00_5A_00; full = 1'b1; we_cnt = 0;
    step();
    chk("t6_owner", 32'(owner), 1);
    for (int c = 0; c < 10; c++) begin
      step();
      we_cnt += int'(write_enable);
      if (gnt != 4'b0000) we_cnt += 100;
    end
    chk("t6_no_we",     32'(we_cnt), 0);
    chk("t6_hold_owner", 32'(owner), 1);
    full = 1'b0;
    step();
    chk("t6_resume_gnt",   32'(gnt), 32'h2);
    chk("t6_resume_owner", 32'(owner), 1);
    step();
    chk("t6_we",   32'(write_enable), 1);
    chk("t6_data", 32'(data_in), 32'h5A);
    req = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
